// File: rtl/out_wrapper_pkg.sv
// out_wrapper_pkg: shared types and helpers for the FP core output stage.
//   state_t     - handshake FSM states (IDLE, PRESENT, RELEASE)
//   FLG_*       - bit positions inside the 4-bit status flag vector
//   classify32  - IEEE754 single-precision class of a 32-bit word
package out_wrapper_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam int FLG_NAN  = 3;
   localparam int FLG_INF  = 2;
   localparam int FLG_ZERO = 1;
   localparam int FLG_SUB  = 0;

   // Returns {nan, inf, zero, subnormal}; normal numbers yield 4'b0000.
   function automatic logic [3:0] classify32(input logic [31:0] v);
      logic [7:0]  exp_f;
      logic [22:0] frac_f;
      logic [3:0]  flg;
      exp_f  = v[30:23];
      frac_f = v[22:0];
      flg    = '0;
      flg[FLG_NAN]  = (exp_f == 8'hFF) && (frac_f != '0);
      flg[FLG_INF]  = (exp_f == 8'hFF) && (frac_f == '0);
      flg[FLG_ZERO] = (exp_f == 8'h00) && (frac_f == '0);
      flg[FLG_SUB]  = (exp_f == 8'h00) && (frac_f != '0);
      return flg;
   endfunction

endpackage

// File: rtl/out_wrapper_fifo.sv
// out_fifo: DEPTH-entry result buffer between the FP core and the handshake FSM.
// Ports:
//   clk, rst      clock / async active-high reset (empties the buffer)
//   push, wdata   write request and data
//   pop           read request; head advances on the edge it is seen
//   head          entry at the read pointer (valid when !empty)
//   count         number of stored entries, $clog2(DEPTH)+1 bits
//   full, empty   status decodes of count
// A push while full is still taken when a pop happens on the same edge,
// because the popped slot is exactly the one being written.
module out_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign head    = mem[rptr];

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_ok) wptr <= wptr + PTR_W'(1);
         if (pop_ok)  rptr <= rptr + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; entries are only observed while count says valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/out_wrapper.sv
// out_wrapper: output stage behind the FP core.
// Buffers doneFP/result pairs in a DEPTH-entry FIFO and hands them to the
// consumer one at a time over a 4-phase outReady/outAccepted handshake.
// Optional feature macro: OUT_STATUS_EN adds the outFlags port
// ({nan,inf,zero,subnormal} of outBus, needs WIDTH==32).
// Ports:
//   clk, rst      clock / async active-high reset
//   doneFP        1-cycle result-valid pulse from the FP core
//   result        FP core result, taken when doneFP=1
//   outBusy       buffer full (combinational), stalls further startFP
//   ovf           sticky: a result was dropped; cleared by rst only
//   outReady      outBus holds a valid result (registered)
//   outBus        presented result (registered)
//   outAccepted   consumer acknowledge
//   outFlags      status class of outBus (OUT_STATUS_EN only)
//
// FSM states:
//   state   | meaning
//   IDLE    | nothing presented; load head into outBus when FIFO not empty
//   PRESENT | outReady=1, outBus stable; pop when outAccepted rises
//   RELEASE | outReady=0; wait for consumer to drop outAccepted
module out_wrapper
   import out_wrapper_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             doneFP,
   input  logic [WIDTH-1:0] result,
   output logic             outBusy,
   output logic             ovf,
   output logic             outReady,
   output logic [WIDTH-1:0] outBus,
   input  logic             outAccepted
`ifdef OUT_STATUS_EN
   ,
   output logic [3:0]       outFlags
`endif
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   state_t           state;
   state_t           state_nxt;
   logic             load_bus;
   logic             pop;
   logic             drop;
   logic [WIDTH-1:0] fifo_head;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;

   out_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (doneFP),
      .wdata (result),
      .pop   (pop),
      .head  (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign outBusy = (fifo_count == CNT_W'(DEPTH));
   assign drop    = doneFP && fifo_full && !pop;

   always_comb begin
      state_nxt = state;
      load_bus  = 1'b0;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               load_bus  = 1'b1;
               state_nxt = PRESENT;
            end
         end
         PRESENT: begin
            if (outAccepted) begin
               pop       = 1'b1;
               state_nxt = RELEASE;
            end
         end
         RELEASE: begin
            if (!outAccepted) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         outReady <= 1'b0;
         outBus   <= '0;
         ovf      <= 1'b0;
      end else begin
         state    <= state_nxt;
         // Registered decode: high exactly while state is PRESENT.
         outReady <= (state_nxt == PRESENT);
         if (load_bus) outBus <= fifo_head;
         if (drop)     ovf    <= 1'b1;
      end
   end

`ifdef OUT_STATUS_EN
   if (WIDTH != 32) begin : g_width_chk
      $error("out_wrapper: OUT_STATUS_EN needs WIDTH == 32");
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outFlags <= '0;
      end else if (load_bus) begin
         outFlags <= classify32(fifo_head[31:0]);
      end
   end
`endif

endmodule
